// File: rtl/timer_irq_if.sv
// Register-window bus between the system bridge and the timer interrupt source.
// The master drives select/strobe/data; the slave returns read data and the level irq.
interface timer_irq_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, we, din, input dout, irq);
  modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_irq_source.sv
// Programmable down-counting timer with 8-bit prescaler, one-shot/auto-reload modes,
// and a software-cleared pending flag that drives a level interrupt request.
module timer_irq_source (
  input  logic         clk,
  input  logic         rst,
  timer_irq_if.slave   bus
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [7:0]  psc;
  logic [31:0] preset;
  logic [31:0] count;
  logic [7:0]  psc_cnt;
  logic        pend;

  logic wr_ctrl, wr_preset, wr_status;

  assign wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL);
  assign wr_preset = bus.we && (bus.addr == ADDR_PRESET);
  assign wr_status = bus.we && (bus.addr == ADDR_STATUS);

  // Reserved MODE encodings fall back to one-shot.
  logic auto_reload;
  assign auto_reload = (mode == 2'b01);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      en      <= 1'b0;
      mode    <= 2'b00;
      im      <= 1'b0;
      psc     <= 8'd0;
      preset  <= 32'd0;
      count   <= 32'd0;
      psc_cnt <= 8'd0;
      pend    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments to the same register later in this block
      // override earlier ones, which is how the simultaneous-event priorities are
      // expressed: the terminal-count set follows the STATUS clear, and the CTRL
      // write follows the one-shot EN auto-clear.
      if (wr_status && bus.din[0]) pend <= 1'b0;
      if (wr_preset) preset <= bus.din;

      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count   <= preset;
          psc_cnt <= 8'd0;
          state   <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (psc_cnt == psc) begin
            psc_cnt <= 8'd0;
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count <= 32'd0;
              pend  <= 1'b1;
              state <= INT;
            end
          end else begin
            psc_cnt <= psc_cnt + 8'd1;
          end
        end
        INT: begin
          if (auto_reload) begin
            state <= LOAD;
          end else begin
            en    <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_ctrl) begin
        en   <= bus.din[0];
        mode <= bus.din[2:1];
        im   <= bus.din[3];
        psc  <= bus.din[15:8];
      end
    end
  end

  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      ADDR_CTRL:   bus.dout = {16'd0, psc, 4'd0, im, mode, en};
      ADDR_PRESET: bus.dout = preset;
      ADDR_COUNT:  bus.dout = count;
      ADDR_STATUS: bus.dout = {31'd0, pend};
      default:     bus.dout = 32'd0;
    endcase
  end

  assign bus.irq = pend & im;

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed and randomized checks of timer_irq_source against timing rules computed
// arithmetically from PRESET, PSC and MODE.
module tb_timer_irq_source;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  timer_irq_if bus ();

  timer_irq_source dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.dout, exp);
  endtask

  // Reference timeline: EN at edge N, COUNT=PRESET at N+2, decrements every PSC+1
  // edges, terminal count at N+2+P*(PSC+1); auto-reload repeats every P*(PSC+1)+2.
  task automatic run_timer(input logic [31:0] pre, input int psc, input logic [1:0] mode,
                           input logic im, input int nper, input bit clean);
    int          p, per, tterm, k;
    logic [31:0] ctrl, cexp;
    bit          auto_mode;
    p         = (pre == 0) ? 1 : int'(pre);
    per       = p * (psc + 1);
    auto_mode = (mode == 2'b01);
    ctrl      = {16'h0, 8'(psc), 4'h0, im, mode, 1'b1};
    write_reg(ADDR_PRESET, pre);
    write_reg(ADDR_CTRL, ctrl);
    tterm = cyc + 2 + per;
    for (int r = 0; r < nper; r++) begin
      while (cyc < tterm) begin
        step();
        k = cyc - (tterm - per);
        if (cyc == tterm) begin
          expect_reg("count_tc", ADDR_COUNT, 32'd0);
          expect_reg("pend_set", ADDR_STATUS, 32'd1);
          check("irq_tc", 32'(bus.irq), 32'(im));
        end else begin
          if (k >= 0) begin
            cexp = (pre == 0) ? 32'd0 : 32'(int'(pre) - k / (psc + 1));
            expect_reg("count", ADDR_COUNT, cexp);
          end
          expect_reg("pend_low", ADDR_STATUS, 32'd0);
        end
      end
      if (auto_mode && r < nper - 1) begin
        write_reg(ADDR_STATUS, 32'd1);
        expect_reg("pend_sw_clr", ADDR_STATUS, 32'd0);
        tterm = tterm + per + 2;
      end
    end
    if (!auto_mode) begin
      step();
      expect_reg("ctrl_en_clr", ADDR_CTRL, ctrl & ~32'h1);
      check("irq_hold", 32'(bus.irq), 32'(im));
    end
    if (clean) begin
      write_reg(ADDR_CTRL, 32'd0);
      step(); step(); step();
      write_reg(ADDR_STATUS, 32'd1);
      expect_reg("pend_clr", ADDR_STATUS, 32'd0);
      check("irq_clr", 32'(bus.irq), 32'd0);
    end
  endtask

  initial begin
    int n;
    bus.addr = 2'd0;
    bus.we   = 1'b0;
    bus.din  = 32'd0;
    #25 rst = 1'b0;
    step();

    // Reset state
    check("rst_irq", 32'(bus.irq), 32'd0);
    for (int a = 0; a < 4; a++) expect_reg("rst_reg", 2'(a), 32'd0);

    // One-shot: PRESET=3, PSC=0, EN+IM; irq holds until STATUS written with 1
    run_timer(32'd3, 0, 2'b00, 1'b1, 1, 1'b0);
    step(); step();
    check("os_irq_held", 32'(bus.irq), 32'd1);
    write_reg(ADDR_STATUS, 32'd0);
    expect_reg("os_status_w0", ADDR_STATUS, 32'd1);
    write_reg(ADDR_STATUS, 32'd1);
    check("os_irq_cleared", 32'(bus.irq), 32'd0);
    write_reg(ADDR_CTRL, 32'd0);

    // Auto-reload: PRESET=4, PSC=1, three periods of 10 cycles
    run_timer(32'd4, 1, 2'b01, 1'b1, 3, 1'b1);

    // Mask: pend sets with IM=0, irq rises as soon as IM is written
    run_timer(32'd3, 0, 2'b00, 1'b0, 1, 1'b0);
    check("mask_irq_low", 32'(bus.irq), 32'd0);
    write_reg(ADDR_CTRL, 32'h8);
    check("mask_irq_unmask", 32'(bus.irq), 32'd1);
    write_reg(ADDR_STATUS, 32'd1);
    check("mask_irq_clr", 32'(bus.irq), 32'd0);
    write_reg(ADDR_CTRL, 32'd0);

    // Race: STATUS clear on the terminal-count edge, set wins
    write_reg(ADDR_PRESET, 32'd2);
    write_reg(ADDR_CTRL, 32'h9);
    n = cyc;
    while (cyc < n + 3) step();
    write_reg(ADDR_STATUS, 32'd1);
    check("race_edge", cyc, n + 4);
    expect_reg("race_pend", ADDR_STATUS, 32'd1);
    step();
    write_reg(ADDR_STATUS, 32'd1);
    expect_reg("race_clr", ADDR_STATUS, 32'd0);

    // PRESET rewritten mid-count only affects the next reload
    write_reg(ADDR_PRESET, 32'd3);
    write_reg(ADDR_CTRL, 32'h3);
    n = cyc;
    while (cyc < n + 3) step();
    write_reg(ADDR_PRESET, 32'd5);
    expect_reg("rw_count_old", ADDR_COUNT, 32'd1);
    step();
    expect_reg("rw_pend_old", ADDR_STATUS, 32'd1);
    write_reg(ADDR_STATUS, 32'd1);
    step();
    expect_reg("rw_count_new", ADDR_COUNT, 32'd5);
    while (cyc < n + 11) begin
      step();
      expect_reg("rw_pend_low", ADDR_STATUS, 32'd0);
    end
    step();
    expect_reg("rw_pend_new", ADDR_STATUS, 32'd1);
    write_reg(ADDR_CTRL, 32'd0);
    step(); step(); step();
    write_reg(ADDR_STATUS, 32'd1);

    // EN cleared in CNT freezes COUNT; COUNT writes are ignored
    write_reg(ADDR_PRESET, 32'd10);
    write_reg(ADDR_CTRL, 32'h1);
    n = cyc;
    while (cyc < n + 5) step();
    expect_reg("frz_count7", ADDR_COUNT, 32'd7);
    write_reg(ADDR_CTRL, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_reg("frz_count", ADDR_COUNT, 32'd6);
    end
    write_reg(ADDR_COUNT, 32'h55);
    expect_reg("count_ro", ADDR_COUNT, 32'd6);
    expect_reg("frz_pend", ADDR_STATUS, 32'd0);

    // Corners: PRESET=0 behaves as 1; PSC=255 with PRESET=1
    run_timer(32'd0, 0, 2'b00, 1'b1, 1, 1'b1);
    run_timer(32'd1, 255, 2'b00, 1'b1, 1, 1'b1);

    // Async reset mid-count with irq high
    write_reg(ADDR_PRESET, 32'd2);
    write_reg(ADDR_CTRL, 32'hB);
    n = cyc;
    while (cyc < n + 4) step();
    check("arst_irq_pre", 32'(bus.irq), 32'd1);
    step(); step();
    #1 rst = 1'b1;
    #1;
    check("arst_irq", 32'(bus.irq), 32'd0);
    for (int a = 0; a < 4; a++) expect_reg("arst_reg", 2'(a), 32'd0);
    rst = 1'b0;
    write_reg(ADDR_PRESET, 32'd5);
    step(); step(); step(); step();
    expect_reg("arst_no_restart", ADDR_COUNT, 32'd0);
    expect_reg("arst_ctrl", ADDR_CTRL, 32'd0);
    expect_reg("arst_pend", ADDR_STATUS, 32'd0);

    // Randomized runs across PRESET, PSC, MODE (incl. reserved) and IM
    for (int i = 0; i < 8; i++) begin
      run_timer(32'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_irq_source.md
# timer_irq_source

Programmable down-counting timer that is the interrupt source on the far end of the CPU's hardware-interrupt interface. Software programs it through a word-addressed register window behind the system bridge. It asserts a level interrupt request that drives one bit of the coprocessor's 6-bit HWInt input, and holds that request until software clears it. It supports one-shot and auto-reload modes, with an 8-bit prescaler.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- addr  in  2  register select, byte address bits [3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS
- we  in  1  register write strobe, sampled on posedge clk
- din  in  32  write data
- dout  out  32  read data, combinational from addr
- irq  out  1  interrupt request to HWInt; irq = pend & IM

## Operation
- **CTRL fields:**
  - [0] EN: counter enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x reserved and treated as 00.
  - [3] IM: interrupt mask.
  - [15:8] PSC: prescaler.
  - Other bits read as 0.
- **PRESET:** 32-bit reload value, read/write.
- **COUNT:** current count, read-only; writes are ignored.
- **STATUS:** bit [0] is pend. Writing with din[0]=1 clears pend; din[0]=0 has no effect. Other bits read as 0.
- **dout mapping:**
  - addr 0: {16'b0, PSC, 4'b0, IM, MODE, EN}
  - addr 1: PRESET
  - addr 2: COUNT
  - addr 3: {31'b0, pend}
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 → LOAD.
  - LOAD: COUNT ← PRESET; prescale counter psc_cnt ← 0; → CNT.
  - CNT, with EN=0: → IDLE. COUNT is frozen.
  - CNT, with EN=1: a tick occurs when psc_cnt == PSC, and psc_cnt then ← 0; otherwise psc_cnt increments.
    - On a tick with COUNT > 1: COUNT ← COUNT−1.
    - On a tick with COUNT ≤ 1: COUNT ← 0, pend ← 1, → INT.
  - INT, MODE 01: → LOAD.
  - INT, otherwise: EN ← 0, → IDLE.
- PRESET=0 behaves like PRESET=1.
- A PRESET write during counting takes effect only at the next LOAD.
- If pend is already 1 at a terminal count, it stays 1. No overrun count is kept.
- IM gates only irq. pend is set regardless of IM.

## Timing
- **Reset:** state IDLE; CTRL, PRESET, COUNT, psc_cnt and pend all 0. Consequently irq=0 and dout=0 for every addr.
- **Register writes:** take effect at the clk edge where we=1. Reads are combinational in the same cycle.
- **First interrupt:** EN written at edge N → LOAD at N+1 → CNT with COUNT=PRESET at N+2 → pend and irq rise at edge N+2+P·(PSC+1), where P = max(PRESET, 1).
- **Auto-reload period:** P·(PSC+1)+2 cycles between successive pend-set edges.
- **irq latency:** irq follows pend/IM with no extra latency (combinational).
- **Simultaneous events:**
  - A STATUS clear in the same cycle as a terminal-count set: set wins, pend=1.
  - A CTRL write in the same cycle as the one-shot EN auto-clear in INT: the software write wins.
  - A CTRL write with EN=0 in CNT: IDLE at the next edge, with COUNT holding its last value.
  - Re-enabling from IDLE always passes through LOAD, so COUNT restarts from PRESET.
- **Async reset mid-count:** all state and outputs return to their reset values immediately, with irq=0 before the next edge.

## Test plan
- **Reset:** assert rst mid-count with irq=1 → irq=0 immediately; every addr reads 0; FSM restarts only after EN is written.
- **One-shot:** PRESET=3, PSC=0, CTRL=0x9 (EN, IM, MODE 00) at edge N.
  - COUNT reads 3, 2, 1 at N+2..N+4.
  - irq=1 and COUNT=0 at N+5.
  - CTRL then reads 0x8 (EN cleared).
  - irq stays 1 until STATUS is written with 1.
- **Auto-reload:** PRESET=4, PSC=1, CTRL=0xB.
  - First pend at N+10.
  - Subsequent pend-set edges every 10 cycles, with pend cleared by software between them.
- **Mask:** same as the one-shot case with IM=0 → STATUS reads 1 and irq stays 0; then write IM=1 → irq=1 in the same cycle.
- **Races:**
  - STATUS clear coincident with terminal count → pend=1.
  - PRESET rewritten mid-count → current run is unaffected; the next reload uses the new value.
- **Corners:**
  - PRESET=0, PSC=0 → pend at N+3.
  - PSC=255, PRESET=1 → pend at N+258.
  - Writing COUNT has no effect.
